filter_anomaly_detector: RTL

- Downstream consumer of the moving-average filter's output stream: one filtered sample per result_valid pulse.
- Flags sustained out-of-range levels and excessive sample-to-sample change on those samples.
- Raises a sticky alarm with a cause code and a saturating event counter for the sensors/security monitor.

---
 rtl/filter_anomaly_detector.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/filter_anomaly_detector.sv
// Anomaly detector on the moving-average filter output: out-of-range and rate
// violations with persistence, a sticky alarm that clears only with hysteresis, and a saturating event count.
module filter_anomaly_detector #(
  parameter int DATA_WIDTH = 8,
  parameter int HYST       = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic [DATA_WIDTH-1:0] thr_high,
  input  logic [DATA_WIDTH-1:0] thr_low,
  input  logic [DATA_WIDTH-1:0] max_delta,
  input  logic [3:0]            persist_count,
  input  logic                  alarm_clear,
  output logic                  alarm,
  output logic                  alarm_pulse,
  output logic [2:0]            cause,
  output logic [1:0]            state,
  output logic [CNT_WIDTH-1:0]  event_count
);

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'b00,
    ST_PENDING = 2'b01,
    ST_ALARM   = 2'b10
  } state_t;

  localparam int EW = DATA_WIDTH + 1;
  localparam logic [EW-1:0] HYST_E = EW'(HYST);

  state_t                state_q, state_d;
  logic [3:0]            viol_cnt_q, viol_cnt_d;
  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic                  have_prev_q, have_prev_d;
  logic                  in_band_q, in_band_d;
  logic                  alarm_q, alarm_d;
  logic                  pulse_q, pulse_d;
  logic [2:0]            cause_q, cause_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;

  logic [EW-1:0]  smp_e, diff, lo_sum, smp_sum;
  logic           over, under, rate, viol, in_band_new, enter;
  logic [3:0]     p_eff;
  logic [4:0]     cnt_inc;
  logic [CNT_WIDTH-1:0] count_inc;

  // Comparisons are done one bit wider than the data so the rate difference
  // and the hysteresis sums can never wrap.
  assign smp_e       = {1'b0, sample_in};
  assign diff        = (sample_in >= prev_q) ? (smp_e - {1'b0, prev_q})
                                             : ({1'b0, prev_q} - smp_e);
  assign over        = sample_in > thr_high;
  assign under       = sample_in < thr_low;
  assign rate        = have_prev_q && (diff > {1'b0, max_delta});
  assign viol        = over | under | rate;
  assign lo_sum      = {1'b0, thr_low} + HYST_E;
  assign smp_sum     = smp_e + HYST_E;
  assign in_band_new = (smp_e >= lo_sum) && (smp_sum <= {1'b0, thr_high});
  assign p_eff       = (persist_count == 4'd0) ? 4'd1 : persist_count;
  assign cnt_inc     = {1'b0, viol_cnt_q} + 5'd1;
  assign count_inc   = (&count_q) ? count_q : count_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    viol_cnt_d  = viol_cnt_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    in_band_d   = in_band_q;
    alarm_d     = alarm_q;
    pulse_d     = 1'b0;
    cause_d     = cause_q;
    count_d     = count_q;
    enter       = 1'b0;

    if (!enable) begin
      state_d     = ST_NORMAL;
      alarm_d     = 1'b0;
      cause_d     = 3'b000;
      viol_cnt_d  = 4'd0;
      have_prev_d = 1'b0;
      in_band_d   = 1'b0;
    end else begin
      if (sample_valid) begin
        prev_d      = sample_in;
        have_prev_d = 1'b1;
        in_band_d   = in_band_new;
      end
      case (state_q)
        ST_NORMAL: begin
          if (sample_valid && viol) begin
            if (p_eff == 4'd1) begin
              enter = 1'b1;
            end else begin
              state_d    = ST_PENDING;
              viol_cnt_d = 4'd1;
            end
          end
        end
        ST_PENDING: begin
          if (sample_valid) begin
            if (!viol) begin
              state_d    = ST_NORMAL;
              viol_cnt_d = 4'd0;
            end else if (cnt_inc >= {1'b0, p_eff}) begin
              // A persist_count lowered mid-run below the count still alarms.
              enter = 1'b1;
            end else begin
              viol_cnt_d = cnt_inc[3:0];
            end
          end
        end
        ST_ALARM: begin
          // in_band_q is the value from before any same-cycle sample.
          if (alarm_clear && in_band_q) begin
            state_d    = ST_NORMAL;
            alarm_d    = 1'b0;
            cause_d    = 3'b000;
            viol_cnt_d = 4'd0;
          end
        end
        default: state_d = ST_NORMAL;
      endcase
      if (enter) begin
        state_d    = ST_ALARM;
        alarm_d    = 1'b1;
        pulse_d    = 1'b1;
        cause_d    = {rate, under, over};
        viol_cnt_d = 4'd0;
        count_d    = count_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_NORMAL;
      viol_cnt_q  <= 4'd0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      in_band_q   <= 1'b0;
      alarm_q     <= 1'b0;
      pulse_q     <= 1'b0;
      cause_q     <= 3'b000;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      viol_cnt_q  <= viol_cnt_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      in_band_q   <= in_band_d;
      alarm_q     <= alarm_d;
      pulse_q     <= pulse_d;
      cause_q     <= cause_d;
      count_q     <= count_d;
    end
  end

  assign alarm       = alarm_q;
  assign alarm_pulse = pulse_q;
  assign cause       = cause_q;
  assign state       = state_q;
  assign event_count = count_q;

endmodule
